spram: RTL and testbench
========================

# spram

Two-port synchronous RAM of `Depth` words × `DataWidth` bits with independent read/write ports, port 1 and port 2. Both ports share one clock and one chip select. Used as a small on-chip scratch/register-file store where two agents access memory in the same cycle. Despite its name, the block is true dual-port: both ports can read or write each cycle.

## Interface
Parameters:
- `AddrWidth`, default 4: address width of each port.
- `DataWidth`, default 32: word width.
- `Depth`, default 16: number of words; must satisfy `Depth <= 2**AddrWidth`.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst_n`: input, 1 bit. Reset, asynchronous and active-low.
- `cs`: input, 1 bit. Chip select, common to both ports; when 0, neither port does anything.
- `addr1`: input, `AddrWidth` bits. Port 1 address.
- `wr1`: input, 1 bit. Port 1 write enable.
- `rd1`: input, 1 bit. Port 1 read enable.
- `Wrdata1`: input, `DataWidth` bits. Port 1 write data.
- `Rddata1`: output, `DataWidth` bits. Port 1 registered read data.
- `addr2`, `wr2`, `rd2`, `Wrdata2`, `Rddata2`: same as the port 1 signals, for port 2.

## Operation
- Write: on a rising `clk` edge with `cs & wrN`, `mem[addrN] <= WrdataN`.
- Read: on a rising `clk` edge with `cs & rdN`, `RddataN <= mem[addrN]`.
- Read data hold: `RddataN` keeps its last value whenever `cs & rdN` is 0.
- Read-before-write: a read of an address written in the same cycle, by either port, returns the old contents.
- Same-port read and write: `rdN` and `wrN` may both be 1. The write happens, and the read returns the old data.
- Write collision: if both ports write the same address in the same cycle, port 1 wins and port 2's write is dropped.
- Out-of-range address (`addrN >= Depth`): writes are ignored; reads load 0 into `RddataN`.
- Reset (`rst_n` low, asynchronous):
  - Every memory word clears to 0.
  - `Rddata1` and `Rddata2` clear to 0.
  - Reset wins over any concurrent access; an access during the reset edge is lost.
- After `rst_n` deasserts, the first rising edge is a normal operating edge.

## Timing
- Write latency: data is visible to a read issued on the next edge. Write at edge k, read at edge k+1, `RddataN` valid after edge k+1.
- Read latency: 1 cycle. Address and `rdN` are sampled at edge k; `RddataN` is valid from edge k until the next read.
- No handshake and no stalls; an access can be issued every cycle on each port.
- All inputs are sampled only at the rising edge; outputs change only on the rising edge or on reset assertion.
- No combinational path from any input to `Rddata1`/`Rddata2`.

## Structure
- Memory: flop-based array `mem[0:Depth-1]`, required because reset clears it.
- Shared package: none required. Put parameter defaults and the `Depth <= 2**AddrWidth` elaboration check in the module.
- One sub-module is natural: `spram_rdport`. It is the registered read mux with range check, hold and reset, instantiated once per port.
- Write-collision priority is handled in the top-level write loop.

## Test plan
- Reset: assert `rst_n`=0 mid-run → `Rddata1`=`Rddata2`=0 immediately. After release, reading addr 0 and addr 15 returns 0.
- Dual write then read:
  - Write phase, cs=1 and wr1=wr2=1 for i=0..9: port 1 writes addr i, port 2 writes addr 15−i, both with random data.
  - Read phase, rd1=rd2=1: same address pattern.
  - Required: each `RddataN` equals the written value one cycle after its address is presented.
- Chip select off: cs=0 with wr1=1, addr1=3, Wrdata1=32'hDEADBEEF → mem[3] unchanged, and `Rddata1` holds its previous value.
- Write collision: wr1=wr2=1, addr1=addr2=5, Wrdata1=32'h1111_1111, Wrdata2=32'h2222_2222 → a later read of addr 5 returns 32'h1111_1111.
- Read-during-write: mem[7]=32'hA5A5A5A5; then in one cycle wr1=1 with addr1=7, Wrdata1=32'h0F0F0F0F, and rd2=1 with addr2=7.
  - `Rddata2`=32'hA5A5A5A5.
  - A read of addr 7 on the next cycle returns 32'h0F0F0F0F.
- Out of range: instantiate with Depth=12. Write addr 13 with 32'hFFFFFFFF, then read addr 13 → `Rddata1`=0, and addresses 0–11 are unchanged.

Source files
------------

// File: rtl/spram_pkg.sv
// Shared helpers for the spram two-port register-file store.
package spram_pkg;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/spram_if.sv
// Two-port access bundle: shared chip select plus one address/control/data group per port.
interface spram_if #(
    parameter int unsigned AddrWidth = 4,
    parameter int unsigned DataWidth = 32
);
    logic                 cs;
    logic [AddrWidth-1:0] addr1;
    logic                 wr1;
    logic                 rd1;
    logic [DataWidth-1:0] Wrdata1;
    logic [DataWidth-1:0] Rddata1;
    logic [AddrWidth-1:0] addr2;
    logic                 wr2;
    logic                 rd2;
    logic [DataWidth-1:0] Wrdata2;
    logic [DataWidth-1:0] Rddata2;

    modport master (
        output cs, addr1, wr1, rd1, Wrdata1, addr2, wr2, rd2, Wrdata2,
        input  Rddata1, Rddata2
    );

    modport slave (
        input  cs, addr1, wr1, rd1, Wrdata1, addr2, wr2, rd2, Wrdata2,
        output Rddata1, Rddata2
    );
endinterface

// File: rtl/spram_rdport.sv
// Registered read mux for one port: out-of-range addresses read as zero, data holds when idle.
module spram_rdport
    import spram_pkg::*;
#(
    parameter int unsigned AddrWidth = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic [AddrWidth-1:0] i_addr,
    input  logic [DataWidth-1:0] i_mem [Depth],
    output logic [DataWidth-1:0] o_data
);
    logic [DataWidth-1:0] w_word;
    logic [DataWidth-1:0] r_data;

    always_comb begin
        w_word = '0;
        if (addr_in_range(32'(i_addr), Depth)) begin
            w_word = i_mem[i_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= w_word;
        end
    end

    assign o_data = r_data;
endmodule

// File: rtl/spram.sv
// True two-port flop-based RAM with reset-clearable contents; port 1 wins same-address write collisions.
module spram
    import spram_pkg::*;
#(
    parameter int unsigned AddrWidth = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    spram_if.slave bus
);
    if (Depth > 2**AddrWidth) begin : g_bad_depth
        $error("spram: Depth must not exceed 2**AddrWidth");
    end

    logic [DataWidth-1:0] r_mem [Depth];
    logic                 w_wr1;
    logic                 w_wr2;

    // Out-of-range writes are dropped here so the loop below never sees them.
    assign w_wr1 = bus.cs & bus.wr1 & addr_in_range(32'(bus.addr1), Depth);
    assign w_wr2 = bus.cs & bus.wr2 & addr_in_range(32'(bus.addr2), Depth);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < Depth; i++) begin
                if (w_wr1 && (32'(bus.addr1) == i)) begin
                    r_mem[i] <= bus.Wrdata1;
                end else if (w_wr2 && (32'(bus.addr2) == i)) begin
                    r_mem[i] <= bus.Wrdata2;
                end
            end
        end
    end

    spram_rdport #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_rd1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (bus.cs & bus.rd1),
        .i_addr (bus.addr1),
        .i_mem  (r_mem),
        .o_data (bus.Rddata1)
    );

    spram_rdport #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_rd2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (bus.cs & bus.rd2),
        .i_addr (bus.addr2),
        .i_mem  (r_mem),
        .o_data (bus.Rddata2)
    );
endmodule

// File: tb/tb_spram.sv
// Directed bench for spram: a full-depth instance and a Depth=12 instance sharing clock and reset.
module tb_spram;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;

    logic [31:0] exp_mem [16];
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] held;

    spram_if #(.AddrWidth(4), .DataWidth(32)) bus16 ();
    spram_if #(.AddrWidth(4), .DataWidth(32)) bus12 ();

    spram #(.AddrWidth(4), .DataWidth(32), .Depth(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    spram #(.AddrWidth(4), .DataWidth(32), .Depth(12)) u_dut12 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus12.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle16();
        bus16.cs = 1'b0; bus16.wr1 = 1'b0; bus16.rd1 = 1'b0; bus16.wr2 = 1'b0; bus16.rd2 = 1'b0;
    endtask

    task automatic idle12();
        bus12.cs = 1'b0; bus12.wr1 = 1'b0; bus12.rd1 = 1'b0; bus12.wr2 = 1'b0; bus12.rd2 = 1'b0;
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle16();
        idle12();
        bus16.addr1 = '0; bus16.addr2 = '0; bus16.Wrdata1 = '0; bus16.Wrdata2 = '0;
        bus12.addr1 = '0; bus12.addr2 = '0; bus12.Wrdata1 = '0; bus12.Wrdata2 = '0;
        for (int i = 0; i < 16; i++) exp_mem[i] = '0;

        // Power-on reset state
        tick();
        tick();
        chk("por_rd1", bus16.Rddata1, 32'h0);
        chk("por_rd2", bus16.Rddata2, 32'h0);
        rst_n = 1'b1;

        bus16.cs = 1'b1; bus16.rd1 = 1'b1; bus16.rd2 = 1'b1;
        bus16.addr1 = 4'd0; bus16.addr2 = 4'd15;
        tick();
        chk("rst_rd_a0", bus16.Rddata1, 32'h0);
        chk("rst_rd_a15", bus16.Rddata2, 32'h0);

        // Dual write phase: port 1 ascends, port 2 descends; later writes overwrite earlier ones
        bus16.rd1 = 1'b0; bus16.rd2 = 1'b0;
        bus16.wr1 = 1'b1; bus16.wr2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d1 = $urandom;
            d2 = $urandom;
            bus16.addr1 = 4'(i);
            bus16.addr2 = 4'(15 - i);
            bus16.Wrdata1 = d1;
            bus16.Wrdata2 = d2;
            tick();
            exp_mem[15 - i] = d2;
            exp_mem[i] = d1;
        end

        bus16.wr1 = 1'b0; bus16.wr2 = 1'b0;
        bus16.rd1 = 1'b1; bus16.rd2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus16.addr1 = 4'(i);
            bus16.addr2 = 4'(15 - i);
            tick();
            chk($sformatf("dual_rd1_a%0d", i), bus16.Rddata1, exp_mem[i]);
            chk($sformatf("dual_rd2_a%0d", 15 - i), bus16.Rddata2, exp_mem[15 - i]);
        end

        // Chip select off: write is dropped and read data holds
        bus16.rd2 = 1'b0;
        bus16.addr1 = 4'd0;
        tick();
        held = bus16.Rddata1;
        chk("cs_pre_rd", held, exp_mem[0]);
        bus16.cs = 1'b0; bus16.wr1 = 1'b1; bus16.rd1 = 1'b1;
        bus16.addr1 = 4'd3; bus16.Wrdata1 = 32'hDEADBEEF;
        tick();
        chk("cs_off_hold", bus16.Rddata1, exp_mem[0]);
        bus16.cs = 1'b1; bus16.wr1 = 1'b0;
        tick();
        chk("cs_off_mem3", bus16.Rddata1, exp_mem[3]);

        // Write collision on address 5
        bus16.rd1 = 1'b0;
        bus16.wr1 = 1'b1; bus16.wr2 = 1'b1;
        bus16.addr1 = 4'd5; bus16.addr2 = 4'd5;
        bus16.Wrdata1 = 32'h1111_1111; bus16.Wrdata2 = 32'h2222_2222;
        tick();
        bus16.wr1 = 1'b0; bus16.wr2 = 1'b0;
        bus16.rd1 = 1'b1; bus16.rd2 = 1'b1;
        tick();
        chk("collide_rd1", bus16.Rddata1, 32'h1111_1111);
        chk("collide_rd2", bus16.Rddata2, 32'h1111_1111);

        // Read-during-write on address 7, from the other port and the same port
        bus16.rd1 = 1'b0; bus16.rd2 = 1'b0;
        bus16.wr1 = 1'b1; bus16.addr1 = 4'd7; bus16.Wrdata1 = 32'hA5A5A5A5;
        tick();
        bus16.Wrdata1 = 32'h0F0F0F0F;
        bus16.rd1 = 1'b1;
        bus16.rd2 = 1'b1; bus16.addr2 = 4'd7;
        tick();
        chk("rdw_other_port", bus16.Rddata2, 32'hA5A5A5A5);
        chk("rdw_same_port", bus16.Rddata1, 32'hA5A5A5A5);
        bus16.wr1 = 1'b0;
        tick();
        chk("rdw_after_rd1", bus16.Rddata1, 32'h0F0F0F0F);
        chk("rdw_after_rd2", bus16.Rddata2, 32'h0F0F0F0F);

        // Mid-run reset: outputs clear without a clock edge; access during reset is lost
        bus16.wr1 = 1'b1; bus16.addr1 = 4'd2; bus16.Wrdata1 = 32'h7777_7777;
        bus16.rd1 = 1'b0; bus16.rd2 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_rd1", bus16.Rddata1, 32'h0);
        chk("midrst_rd2", bus16.Rddata2, 32'h0);
        tick();
        bus16.wr1 = 1'b0;
        rst_n = 1'b1;
        bus16.rd1 = 1'b1; bus16.rd2 = 1'b1;
        bus16.addr1 = 4'd2; bus16.addr2 = 4'd7;
        tick();
        chk("midrst_mem2", bus16.Rddata1, 32'h0);
        chk("midrst_mem7", bus16.Rddata2, 32'h0);
        idle16();

        // Depth=12 instance: fill all words, then attempt out-of-range writes
        bus12.cs = 1'b1; bus12.wr1 = 1'b1; bus12.wr2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus12.addr1 = 4'(i);
            bus12.addr2 = 4'(i + 6);
            bus12.Wrdata1 = 32'hC0DE_0000 + 32'(i);
            bus12.Wrdata2 = 32'hC0DE_0000 + 32'(i + 6);
            tick();
        end
        bus12.addr1 = 4'd13; bus12.Wrdata1 = 32'hFFFFFFFF;
        bus12.addr2 = 4'd12; bus12.Wrdata2 = 32'hFFFFFFFF;
        tick();
        bus12.wr1 = 1'b0; bus12.wr2 = 1'b0;
        bus12.rd1 = 1'b1; bus12.rd2 = 1'b1;
        bus12.addr1 = 4'd11; bus12.addr2 = 4'd10;
        tick();
        chk("oor_pre_rd1", bus12.Rddata1, 32'hC0DE_000B);
        chk("oor_pre_rd2", bus12.Rddata2, 32'hC0DE_000A);
        bus12.addr1 = 4'd13; bus12.addr2 = 4'd14;
        tick();
        chk("oor_rd_a13", bus12.Rddata1, 32'h0);
        chk("oor_rd_a14", bus12.Rddata2, 32'h0);
        bus12.rd2 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus12.addr1 = 4'(i);
            tick();
            chk($sformatf("oor_keep_a%0d", i), bus12.Rddata1, 32'hC0DE_0000 + 32'(i));
        end
        idle12();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
